// File: rtl/cordic_pkg.sv
// Shared constants and tag bundle for the CORDIC vectoring scheduler.
// Angles are Q3.13 radians; magnitudes carry the raw CORDIC gain.
package cordic_pkg;

    localparam int Q_W      = 16;
    localparam int TAG_ID_W = 3;

    localparam logic [Q_W-1:0] PI_Q13      = 16'h6488;
    localparam logic [Q_W-1:0] HALF_PI_Q13 = 16'h3244;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                flag;
        logic                ys;
    } tag_t;

    // -32768 has no positive twin, so it clamps to +32767
    function automatic logic [Q_W-1:0] neg_sat(input logic [Q_W-1:0] v);
        return (v == 16'h8000) ? 16'h7fff : (~v + 16'd1);
    endfunction

endpackage

// File: rtl/cordic_vec_sched_fifo.sv
// Synchronous FIFO with registered count; output word is visible
// only the cycle after it is written.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          full;

    assign valid  = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign pop_ok = pop && valid;
    assign dout   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && full && !pop_ok));

endmodule

// File: rtl/cordic_vec_sched.sv
// Round-robin front end sharing one CORDIC vectoring pipeline, with
// left-half-plane folding and a credit-guarded result FIFO.
module cordic_vec_sched
    import cordic_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int PIPE_LAT   = 17,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_x,
    input  logic [16*NUM_REQ-1:0]  req_y,
    output logic [15:0]            cordic_xin,
    output logic [15:0]            cordic_yin,
    output logic [15:0]            cordic_zin,
    input  logic [15:0]            cordic_x0,
    input  logic [15:0]            cordic_z0,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_mag,
    output logic [15:0]            rsp_ang
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int INF_W = $clog2(PIPE_LAT + 1);
    localparam int RW    = ID_W + 2 * Q_W;

    if (PI_Q13 != {HALF_PI_Q13[Q_W-2:0], 1'b0}) begin : g_bad_const
        $error("PI_Q13 and HALF_PI_Q13 disagree");
    end

    function automatic logic [ID_W-1:0] wrap_id(input int v);
        return ID_W'(v % NUM_REQ);
    endfunction

    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  grant;
    logic             found;
    logic             credit;
    logic             hs;
    logic             neg;
    logic [Q_W-1:0]   x_sel;
    logic [Q_W-1:0]   y_sel;
    logic [Q_W-1:0]   ang;
    logic [INF_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [RW-1:0]    fifo_din;
    logic [RW-1:0]    fifo_dout;
    tag_t             tag_q [PIPE_LAT];
    tag_t             tail;

    always_comb begin
        found = 1'b0;
        grant = rr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[wrap_id(int'(rr_q) + k)]) begin
                found = 1'b1;
                grant = wrap_id(int'(rr_q) + k);
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int s = 0; s < PIPE_LAT; s++)
            inflight = inflight + INF_W'(tag_q[s].valid);
    end

    // Credits count what is already committed; a pop frees space next cycle
    assign credit = (int'(inflight) + int'(fifo_count)) < FIFO_DEPTH;

    always_comb begin
        req_ready = '0;
        if (!rst && found && credit) req_ready[grant] = 1'b1;
    end

    assign hs    = |(req_valid & req_ready);
    assign x_sel = req_x[int'(grant)*Q_W +: Q_W];
    assign y_sel = req_y[int'(grant)*Q_W +: Q_W];

    always_comb begin
        cordic_xin = '0;
        cordic_yin = '0;
        neg        = 1'b0;
        if (hs) begin
            if (x_sel[Q_W-1]) begin
                cordic_xin = neg_sat(x_sel);
                cordic_yin = neg_sat(y_sel);
                neg        = 1'b1;
            end else begin
                cordic_xin = x_sel;
                cordic_yin = y_sel;
            end
        end
    end

    assign cordic_zin = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
            for (int s = 0; s < PIPE_LAT; s++) tag_q[s] <= '0;
        end else begin
            if (hs) rr_q <= wrap_id(int'(grant) + 1);
            tag_q[0] <= '{valid: hs, id: TAG_ID_W'(grant),
                          flag: neg, ys: y_sel[Q_W-1]};
            for (int s = 1; s < PIPE_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    assign tail = tag_q[PIPE_LAT-1];

    always_comb begin
        ang = cordic_z0;
        if (tail.flag) ang = tail.ys ? cordic_z0 - PI_Q13 : cordic_z0 + PI_Q13;
    end

    assign fifo_din = {tail.id[ID_W-1:0], cordic_x0, ang};

    sync_fifo #(
        .W     (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tail.valid),
        .din   (fifo_din),
        .pop   (rsp_ready),
        .dout  (fifo_dout),
        .valid (rsp_valid),
        .count (fifo_count)
    );

    assign {rsp_id, rsp_mag, rsp_ang} = fifo_dout;

    a_id_range: assert property (
        @(posedge clk) disable iff (rst) tail.valid |-> int'(tail.id) < NUM_REQ);

endmodule

// File: tb/tb_cordic_vec_sched.sv
// Scoreboard bench for cordic_vec_sched with an ideal CORDIC pipeline
// model and an atan2/sqrt reference.
module tb_cordic_vec_sched;
    localparam int NR = 4;
    localparam int PL = 17;
    localparam int FD = 8;
    localparam int IW = 2;
    localparam real K = 1.646760258;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [16*NR-1:0] req_x;
    logic [16*NR-1:0] req_y;
    logic [15:0]     cordic_xin, cordic_yin, cordic_zin;
    logic [15:0]     cordic_x0, cordic_z0;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [15:0]     rsp_mag, rsp_ang;

    always #5 clk = ~clk;

    cordic_vec_sched #(.NUM_REQ(NR), .PIPE_LAT(PL), .FIFO_DEPTH(FD), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .cordic_xin(cordic_xin), .cordic_yin(cordic_yin), .cordic_zin(cordic_zin),
        .cordic_x0(cordic_x0), .cordic_z0(cordic_z0),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_mag(rsp_mag), .rsp_ang(rsp_ang)
    );

    function automatic int rnd(real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    function automatic int f_mag(int x, int y);
        real rx = real'(x);
        real ry = real'(y);
        return rnd(K * $sqrt(rx * rx + ry * ry));
    endfunction

    function automatic int f_ang(int x, int y);
        return rnd($atan2(real'(y), real'(x)) * 8192.0);
    endfunction

    // Ideal unreset CORDIC pipeline: input sampled each edge, PL stages deep
    logic [15:0] px [PL];
    logic [15:0] pz [PL];
    always @(posedge clk) begin
        px[0] <= 16'(f_mag(int'($signed(cordic_xin)), int'($signed(cordic_yin))));
        pz[0] <= 16'(f_ang(int'($signed(cordic_xin)), int'($signed(cordic_yin))));
        for (int k = 1; k < PL; k++) begin
            px[k] <= px[k-1];
            pz[k] <= pz[k-1];
        end
    end
    assign cordic_x0 = px[PL-1];
    assign cordic_z0 = pz[PL-1];

    typedef struct {
        int id;
        int mag;
        int ang;
        int t_iss;
        bit exact;
    } exp_t;

    exp_t exp_q[$];
    int   grants[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_hs = 0;
    int   n_pop = 0;
    int   hs_id = -1;
    bit   lat_exact = 1'b0;

    task automatic chk(string nm, bit ok, int act, int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Issue-side monitor: every handshake pushes its expected response
    always @(negedge clk) begin
        int rx, ry;
        exp_t e;
        hs_id = -1;
        if (!rst) begin
            chk("req_ready_onehot0", $onehot0(req_ready), int'(req_ready), 0);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    rx = int'($signed(req_x[16*i +: 16]));
                    ry = int'($signed(req_y[16*i +: 16]));
                    e.id = i;
                    e.mag = f_mag(rx, ry);
                    e.ang = f_ang(rx, ry);
                    e.t_iss = cyc;
                    e.exact = lat_exact;
                    exp_q.push_back(e);
                    grants.push_back(i);
                    n_hs++;
                    hs_id = i;
                end
            end
        end
    end

    // Output-side monitor: pops the scoreboard on each accepted response
    logic [IW-1:0] h_id;
    logic [15:0]   h_mag, h_ang;
    bit            holding = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] d;
        int lat;
        if (rst) begin
            exp_q.delete();
            holding = 1'b0;
        end else begin
            if (holding && rsp_valid)
                chk("rsp_hold_stable",
                    {rsp_id, rsp_mag, rsp_ang} == {h_id, h_mag, h_ang},
                    int'(rsp_mag), int'(h_mag));
            holding = rsp_valid && !rsp_ready;
            h_id = rsp_id;
            h_mag = rsp_mag;
            h_ang = rsp_ang;
            if (rsp_valid && rsp_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1'b0, int'(rsp_id), -1);
                end else begin
                    e = exp_q.pop_front();
                    lat = cyc - e.t_iss;
                    chk("rsp_id", int'(rsp_id) == e.id, int'(rsp_id), e.id);
                    d = rsp_ang - 16'(e.ang);
                    chk("rsp_ang", $signed(d) >= -3 && $signed(d) <= 3,
                        int'($signed(rsp_ang)), e.ang);
                    if (e.mag < 32000) begin
                        d = rsp_mag - 16'(e.mag);
                        chk("rsp_mag", $signed(d) >= -4 && $signed(d) <= 4,
                            int'(rsp_mag), e.mag);
                    end
                    if (e.exact) chk("latency", lat == PL + 1, lat, PL + 1);
                    else chk("latency_min", lat >= PL + 1, lat, PL + 1);
                end
            end
        end
    end

    function automatic logic [15:0] rcoord();
        int v = int'($urandom_range(0, 18000)) - 9000;
        if (v >= 0) v += 3000;
        else v -= 3000;
        return 16'(v);
    endfunction

    task automatic set_req(int i, bit v, logic [15:0] x, logic [15:0] y);
        req_valid[i] = v;
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
    endtask

    task automatic issue_one(int i, logic [15:0] x, logic [15:0] y, bit exact);
        int start;
        @(posedge clk);
        #1;
        start = n_hs;
        lat_exact = exact;
        set_req(i, 1'b1, x, y);
        for (int c = 0; c < 200 && n_hs == start; c++) @(posedge clk);
        if (n_hs == start) chk("issue_timeout", 1'b0, 0, 1);
        #1;
        req_valid[i] = 1'b0;
        lat_exact = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
        chk("drain", exp_q.size() == 0, exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic all_valid_random();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, rcoord(), rcoord());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, g0, p0;
        req_valid = '1;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid == 1'b0, int'(rsp_valid), 0);
        chk("reset_req_ready", req_ready == '0, int'(req_ready), 0);
        chk("reset_rsp_id", rsp_id == '0, int'(rsp_id), 0);
        chk("reset_rsp_mag", rsp_mag == '0, int'(rsp_mag), 0);
        chk("reset_rsp_ang", rsp_ang == '0, int'(rsp_ang), 0);
        chk("reset_zin", cordic_zin == '0, int'(cordic_zin), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        repeat (5) @(posedge clk);

        issue_one(0, 16'h2000, 16'h0000, 1'b1);
        wait_idle();
        issue_one(1, 16'hE000, 16'h0100, 1'b1);
        wait_idle();
        issue_one(2, 16'hE000, 16'hFF00, 1'b1);
        wait_idle();
        issue_one(3, 16'h8000, 16'h0000, 1'b1);
        wait_idle();
        issue_one(0, 16'h0000, 16'h0000, 1'b1);
        wait_idle();

        // Fairness: everyone holds valid, the served one gets fresh data
        g0 = grants.size();
        @(posedge clk);
        #1;
        all_valid_random();
        for (int c = 0; c < 2000 && grants.size() - g0 < 40; c++) begin
            @(posedge clk);
            #1;
            if (hs_id >= 0) set_req(hs_id, 1'b1, rcoord(), rcoord());
        end
        req_valid = '0;
        chk("fair_count", grants.size() - g0 >= 40, grants.size() - g0, 40);
        for (int k = g0 + 1; k < g0 + 40 && k < grants.size(); k++)
            chk("rr_order", grants[k] == (grants[k-1] + 1) % NR, grants[k],
                (grants[k-1] + 1) % NR);
        wait_idle();

        // Backpressure: credits must cap handshakes at the FIFO depth
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        h0 = n_hs;
        all_valid_random();
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (hs_id >= 0) set_req(hs_id, 1'b1, rcoord(), rcoord());
        end
        @(negedge clk);
        chk("bp_handshakes", n_hs - h0 == FD, n_hs - h0, FD);
        chk("bp_req_ready_low", req_ready == '0, int'(req_ready), 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 500 && n_hs - h0 < FD + 12; c++) begin
            @(posedge clk);
            #1;
            if (hs_id >= 0) set_req(hs_id, 1'b1, rcoord(), rcoord());
        end
        req_valid = '0;
        chk("bp_resume", n_hs - h0 >= FD + 12, n_hs - h0, FD + 12);
        wait_idle();

        // Random traffic with a random consumer
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] || hs_id == i)
                    set_req(i, 1'($urandom_range(0, 1)), rcoord(), rcoord());
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while five requests are in flight
        h0 = n_hs;
        @(posedge clk);
        #1;
        all_valid_random();
        for (int c = 0; c < 100 && n_hs - h0 < 5; c++) @(posedge clk);
        #1;
        req_valid = '0;
        chk("pre_reset_issues", n_hs - h0 == 5, n_hs - h0, 5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        p0 = n_pop;
        repeat (40) @(posedge clk);
        chk("no_stale_rsp", n_pop == p0, n_pop - p0, 0);
        issue_one(2, rcoord(), rcoord(), 1'b1);
        wait_idle();
        chk("post_reset_rsp", n_pop == p0 + 1, n_pop - p0, 1);

        chk("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
